// File: rtl/debounce_pulse.sv
// Two-flop synchroniser plus a four-state qualification FSM that debounces a
// mechanical input into a clean level with single-cycle rise/fall strobes.
module debounce_pulse #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic Clk,
   input  logic Rst,
   input  logic BtnIn,
   input  logic Tick,
   output logic Q,
   output logic Rise,
   output logic Fall,
   output logic Busy
);

   localparam logic [1:0] IDLE_LOW  = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Strobes default low, so a Tick=0 edge always clears them.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (Tick) begin
         case (state_q)
            IDLE_LOW: begin
               if (sync2_q) begin
                  state_d = WAIT_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               if (!sync2_q) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_HIGH;
                  q_d     = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!sync2_q) begin
                  state_d = WAIT_LOW;
                  cnt_d   = CNT_ONE;
               end
            end
            WAIT_LOW: begin
               if (sync2_q) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_LOW;
                  q_d     = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= BtnIn;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign Q    = q_q;
   assign Rise = rise_q;
   assign Fall = fall_q;
   assign Busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: expected {Q,Rise,Fall,Busy} per cycle are
// queued as stimulus is applied and compared after the following clock edge.
module tb_debounce_pulse;

   localparam int unsigned S = 4;

   logic Clk = 1'b0;
   logic Rst, BtnIn, Tick;
   logic Q, Rise, Fall, Busy;

   logic [3:0] exp_q[$];
   string      tag_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   debounce_pulse #(
      .STABLE_CYCLES(S),
      .CNT_W        (16)
   ) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .BtnIn(BtnIn),
      .Tick (Tick),
      .Q    (Q),
      .Rise (Rise),
      .Fall (Fall),
      .Busy (Busy)
   );

   always #5 Clk = ~Clk;

   // Expected outputs after edge e of a clean change (edge 1 samples the new level).
   function automatic logic [3:0] change_exp(input int e, input logic to_high);
      if (e < 3)              return to_high ? 4'b0000 : 4'b1000;
      else if (e < int'(S) + 2) return to_high ? 4'b0001 : 4'b1001;
      else if (e == int'(S) + 2) return to_high ? 4'b1100 : 4'b0010;
      else                    return to_high ? 4'b1000 : 4'b0000;
   endfunction

   task automatic check();
      logic [3:0] got, want;
      string      tag;
      got = {Q, Rise, Fall, Busy};
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: got %b required an entry", got);
      end else begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got {Q,Rise,Fall,Busy}=%b required %b", tag, got, want);
         end
      end
   endtask

   task automatic step(input logic rst, input logic btn, input logic tk,
                       input logic [3:0] want, input string tag);
      Rst   = rst;
      BtnIn = btn;
      Tick  = tk;
      exp_q.push_back(want);
      tag_q.push_back(tag);
      @(posedge Clk);
      #1;
      check();
   endtask

   task automatic run_change(input logic to_high, input int n, input string tag);
      for (int e = 1; e <= n; e++)
         step(1'b0, to_high, 1'b1, change_exp(e, to_high), $sformatf("%s_e%0d", tag, e));
   endtask

   initial begin
      Rst = 1'b1; BtnIn = 1'b1; Tick = 1'b1;

      // 1: reset with input held high, then rise after release
      for (int i = 1; i <= 3; i++)
         step(1'b1, 1'b1, (i == 2), 4'b0000, $sformatf("rst_hold_c%0d", i));
      run_change(1'b1, 10, "rst_release_rise");

      // 4b: a single low sample on release is cancelled; Q stays high
      step(1'b0, 1'b0, 1'b1, 4'b1000, "glitch_e1");
      step(1'b0, 1'b1, 1'b1, 4'b1000, "glitch_e2");
      step(1'b0, 1'b1, 1'b1, 4'b1001, "glitch_e3");
      for (int e = 4; e <= 10; e++)
         step(1'b0, 1'b1, 1'b1, 4'b1000, $sformatf("glitch_e%0d", e));

      // 4a: clean release, then 2: clean press held 20 cycles
      run_change(1'b0, 10, "release");
      run_change(1'b1, 20, "press");
      run_change(1'b0, 10, "release2");

      // 3: bounce 3 high, 1 low, 3 high, then low
      begin
         logic [11:0] btn_seq, busy_seq;
         btn_seq  = 12'b0000_0111_0111;  // bit e-1 = BtnIn at edge e
         busy_seq = 12'b0001_1101_1100;  // bit e-1 = Busy after edge e
         for (int e = 1; e <= 12; e++)
            step(1'b0, btn_seq[e-1], 1'b1, {3'b000, busy_seq[e-1]},
                 $sformatf("bounce_e%0d", e));
      end
      run_change(1'b1, 10, "bounce_settle");
      run_change(1'b0, 10, "release3");

      // 5: Tick every 4th cycle, BtnIn held high
      for (int c = 1; c <= 20; c++) begin
         logic [3:0] w;
         if (c < 4)       w = 4'b0000;
         else if (c < 16) w = 4'b0001;
         else if (c == 16) w = 4'b1100;
         else             w = 4'b1000;
         step(1'b0, 1'b1, (c % 4 == 0), w, $sformatf("tick_c%0d", c));
      end
      run_change(1'b0, 10, "release4");

      // 6: reset at edge 4 of a press abandons it; full requalification afterwards
      for (int e = 1; e <= 3; e++)
         step(1'b0, 1'b1, 1'b1, change_exp(e, 1'b1), $sformatf("midrst_e%0d", e));
      step(1'b1, 1'b1, 1'b1, 4'b0000, "midrst_e4");
      run_change(1'b1, 10, "midrst_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
